contador_param: RTL

CONTADOR_PARAM -- requirements
Module: contador_param

---
 rtl/contador_param_if.sv | 26 ++
 rtl/contador_param.sv | 90 +++++++++
 2 files changed

// File: rtl/contador_param_if.sv
// Request/response bus of contador_param: per-channel push/pop strobes, indexed
// read request and registered read result with saturation flags.
interface contador_param_if #(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 6,
  parameter int IDX_W  = 3
);
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic              req;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              err;
  logic [NUM_CH-1:0] sat;

  modport master (
    output push, pop, req, idx,
    input  data, valid, err, sat
  );

  modport slave (
    input  push, pop, req, idx,
    output data, valid, err, sat
  );
endinterface

// File: rtl/contador_param.sv
// Bank of NUM_CH saturating up/down counters with sticky saturation flags and
// a one-cycle registered indexed read port. Define CONTADOR_CLR_ON_READ_EN for clear-on-read.
module contador_param #(
  parameter int NUM_CH = 5,
  parameter int CNT_W  = 4,
  parameter int DATA_W = 6,
  parameter int IDX_W  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  contador_param_if.slave       bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W:0]    stp   [NUM_CH];
  logic [NUM_CH-1:0] sat_q, sat_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              rd_ok;
  logic [CNT_W-1:0]  rd_val;

  // Returns {limit_hit, next_count}; push+pop together is a no-op.
  function automatic logic [CNT_W:0] cnt_step(input logic [CNT_W-1:0] c,
                                               input logic inc,
                                               input logic dec);
    logic [CNT_W:0] r;
    r = {1'b0, c};
    if (inc && !dec) begin
      if (c == CNT_MAX) r[CNT_W] = 1'b1;
      else              r[CNT_W-1:0] = c + 1'b1;
    end else if (dec && !inc) begin
      if (c == '0) r[CNT_W] = 1'b1;
      else         r[CNT_W-1:0] = c - 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    rd_ok  = ({1'b0, bus.idx} < (IDX_W+1)'(NUM_CH));
    rd_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.idx == IDX_W'(i)) rd_val = cnt_q[i];
    end

    sat_d = sat_q;
    for (int i = 0; i < NUM_CH; i++) begin
      stp[i]   = cnt_step(cnt_q[i], bus.push[i], bus.pop[i]);
      cnt_d[i] = stp[i][CNT_W-1:0];
      sat_d[i] = sat_q[i] | stp[i][CNT_W];
`ifdef CONTADOR_CLR_ON_READ_EN
      // The read returns the pre-update count, so the cleared channel only keeps a lone push.
      if (bus.req && (bus.idx == IDX_W'(i))) begin
        cnt_d[i] = (bus.push[i] && !bus.pop[i]) ? CNT_W'(1) : '0;
        sat_d[i] = 1'b0;
      end
`endif
    end

    valid_d = bus.req;
    err_d   = bus.req && !rd_ok;
    data_d  = data_q;
    if (bus.req) data_d = rd_ok ? DATA_W'(rd_val) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      sat_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
      sat_q   <= sat_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;
  assign bus.sat   = sat_q;

endmodule
